letc_axi_sram_subordinate: RTL and testbench
============================================

// Module: letc_axi_sram_subordinate
// PURPOSE
//  AXI subordinate (responder) for the single-beat, 32-bit, fixed-burst traffic the LETC core manager emits.
//  Accepts AR/AW/W, serialises into one-at-a-time accesses on a synchronous 1-cycle-latency SRAM port, returns R/B.
//  Sits on the SoC side of the core AXI port: on-chip RAM/ROM backing and bench memory model.
// PARAMETERS
//  DEPTH_WORDS  1024  SRAM depth in 32-bit words; index width = $clog2(DEPTH_WORDS)
//  BASE_ADDR    0     paddr_t byte address mapped to SRAM word 0; must be 4*DEPTH_WORDS aligned
// PORTS
//  i_clk        in   1                 clock
//  i_rst_n      in   1                 reset, asynchronous, active-low
//  axi          axi_if.subordinate     AR/R/AW/W/B channels, IDWIDTH ids, 34b addr, 32b data, 4b strobe
//  o_mem_req    out  1                 SRAM access strobe, 1 cycle per access
//  o_mem_wen    out  1                 1 = write, 0 = read (valid with o_mem_req)
//  o_mem_idx    out  $clog2(DEPTH)     word index = (addr - BASE_ADDR) >> 2
//  o_mem_wdata  out  32                write data (captured wdata)
//  o_mem_wstrb  out  4                 byte enables (captured wstrb)
//  i_mem_rdata  in   32                read data, valid the cycle after a read o_mem_req
// BEHAVIOUR
//  Reset: state IDLE; all *valid, o_mem_req, o_mem_wen = 0; prefer_read = 1; captured regs = 0.
//  Readies combinational from state; all 0 while i_rst_n low.
//  Reset mid-transaction drops it silently; no R/B issued.
//  FSM: IDLE, WR_COLLECT, WR_MEM, WR_RESP, RD_MEM, RD_CAPTURE, RD_RESP.
//  IDLE arbitration: read chosen if arvalid && (prefer_read || !(awvalid||wvalid)); else write if awvalid||wvalid.
//  Read chosen: arready=1, awready=wready=0; capture araddr/arid; -> RD_MEM.
//  Write chosen: awready=~aw_got, wready=~w_got in IDLE and WR_COLLECT; AW/W may arrive in any order.
//  Write chosen: AW/W may also arrive in the same cycle. Both held -> WR_MEM; else -> WR_COLLECT.
//  WR_MEM: o_mem_req=1, o_mem_wen=1 one cycle -> WR_RESP.
//  WR_RESP: bvalid=1, bid=awid captured, bresp held stable until bready; handshake -> IDLE, prefer_read=1.
//  RD_MEM: o_mem_req=1, o_mem_wen=0 -> RD_CAPTURE (rdata_q <= i_mem_rdata) -> RD_RESP.
//  RD_RESP: rvalid=1, rdata=rdata_q, rid=arid captured, rlast=1, stable until rready.
//  RD_RESP handshake -> IDLE, prefer_read=0.
//  Latency, zero backpressure: read AR hs cycle 0 -> rvalid cycle 3.
//  Latency, zero backpressure: write AW+W hs cycle 0 -> bvalid cycle 2.
//  Throughput: one transaction in flight; new AR/AW not accepted until R/B handshake completes.
//  Alternating prefer_read prevents starvation under continuous simultaneous read and write.
//  Captured address is used word-aligned (bits [1:0] ignored); sub-word handled by wstrb only.
//  wstrb=0 write still issues o_mem_req with wstrb 0 and returns OKAY.
//  arlen/awlen != 0 or burst != FIXED: unsupported, flagged by assertion, treated as single beat.
// CONFIGURATION
//  LETC_AXI_SUB_RANGE_CHECK_EN defined:
//   addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): no o_mem_req (MEM state still spent, latency unchanged).
//   out-of-range read: rresp=DECERR (2'b11), rdata=0. Out-of-range write: bresp=DECERR.
//  Undefined: no compare logic; index = low address bits (aliases); rresp/bresp always OKAY (2'b00).
// STRUCTURE
//  axi_pkg: AXI_RESP_OKAY, AXI_RESP_DECERR, axi_resp_t (add if absent). letc_pkg: paddr_t, word_t reused.
//  state_e local to module. No sub-module; arbitration and range compare are too small to split.
// TESTING
//  Read after reset: SRAM[5]=0xDEADBEEF, AR addr BASE+0x14 id 3 -> rvalid cycle 3, rdata 0xDEADBEEF, rid 3, rlast 1.
//  Write W before AW: W 0x11223344 strb 4'b0100 at cycle 0, AW BASE+0x8 at cycle 2.
//   -> single o_mem_req wen=1 idx 2 strb 4'b0100; bvalid 1; bresp OKAY.
//  Backpressure: rready low 5 cycles -> rvalid and rdata stable throughout; no new arready until handshake.
//  Arbitration: AR and AW+W all valid every cycle for 4 transactions -> order R,W,R,W.
//  Range check, macro defined: AR addr BASE+4*DEPTH -> no o_mem_req, rresp 2'b11, rdata 0.
//  Range check, macro undefined: same AR -> reads SRAM[0], rresp 2'b00.
//  Reset during RD_RESP: assert i_rst_n=0 -> rvalid 0 asynchronously; after release, IDLE with arready 1.

Source files
------------

// File: rtl/letc_axi_sram_subordinate_pkg.sv
// Shared types for the LETC AXI SRAM subordinate: physical address and data
// word types, AXI response codes and the burst encoding the core emits.
// Optional feature macro used by the top: LETC_AXI_SUB_RANGE_CHECK_EN.
package letc_axi_sram_subordinate_pkg;

    // 34-bit physical byte address and 32-bit data word of the LETC core
    typedef logic [33:0] paddr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

endpackage : letc_axi_sram_subordinate_pkg

// File: rtl/letc_axi_sram_subordinate_if.sv
// AXI channel bundle between the LETC core manager and a subordinate.
// Single-beat traffic only: 34-bit address, 32-bit data, 4-bit strobe.
interface letc_axi_sram_subordinate_if #(
    parameter int IDWIDTH = 4
);
    import letc_axi_sram_subordinate_pkg::*;

    // Read address channel
    logic               arvalid;
    logic               arready;
    paddr_t             araddr;
    logic [IDWIDTH-1:0] arid;
    logic [7:0]         arlen;
    logic [1:0]         arburst;

    // Read data channel
    logic               rvalid;
    logic               rready;
    word_t              rdata;
    axi_resp_t          rresp;
    logic [IDWIDTH-1:0] rid;
    logic               rlast;

    // Write address channel
    logic               awvalid;
    logic               awready;
    paddr_t             awaddr;
    logic [IDWIDTH-1:0] awid;
    logic [7:0]         awlen;
    logic [1:0]         awburst;

    // Write data channel
    logic               wvalid;
    logic               wready;
    word_t              wdata;
    logic [3:0]         wstrb;
    logic               wlast;

    // Write response channel
    logic               bvalid;
    logic               bready;
    axi_resp_t          bresp;
    logic [IDWIDTH-1:0] bid;

    modport master (
        output arvalid, araddr, arid, arlen, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface : letc_axi_sram_subordinate_if

// File: rtl/letc_axi_sram_subordinate.sv
// AXI subordinate serving single-beat LETC core traffic from a synchronous
// SRAM with one cycle of read latency. One transaction is in flight at a time;
// reads and writes alternate priority when both are pending.
// Optional feature: define LETC_AXI_SUB_RANGE_CHECK_EN to decode the address
// window and answer DECERR (without touching the SRAM) outside it.
module letc_axi_sram_subordinate
    import letc_axi_sram_subordinate_pkg::*;
#(
    parameter int     DEPTH_WORDS = 1024,
    parameter paddr_t BASE_ADDR   = '0,
    parameter int     IDWIDTH     = 4,
    localparam int    IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    letc_axi_sram_subordinate_if.slave  axi,
    output logic                        o_mem_req,
    output logic                        o_mem_wen,
    output logic [IDX_W-1:0]            o_mem_idx,
    output word_t                       o_mem_wdata,
    output logic [3:0]                  o_mem_wstrb,
    input  word_t                       i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_MEM,
        WR_RESP,
        RD_MEM,
        RD_CAPTURE,
        RD_RESP
    } state_e;

    state_e             state;
    logic               prefer_read;
    logic               aw_got;
    logic               w_got;
    logic [IDX_W-1:0]   idx_q;
    logic [IDWIDTH-1:0] id_q;
    word_t              wdata_q;
    logic [3:0]         wstrb_q;
    word_t              rdata_q;
    axi_resp_t          resp_q;
    logic               rvalid_q;
    logic               bvalid_q;
    logic               mem_req_q;
    logic               mem_wen_q;

    logic rd_sel;
    logic wr_sel;
    logic ar_hs;
    logic aw_hs;
    logic w_hs;
    logic aw_have;
    logic w_have;
    logic wr_access_en;
    logic ar_access_en;

`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
    localparam paddr_t SPAN = paddr_t'(4 * DEPTH_WORDS);

    // Offset relative to the window; addresses below BASE_ADDR wrap to a huge
    // offset, so one unsigned compare covers both ends of the window.
    logic range_ok_q;
    logic ar_in_range;
    logic aw_in_range;

    assign ar_in_range  = (axi.araddr - BASE_ADDR) < SPAN;
    assign aw_in_range  = (axi.awaddr - BASE_ADDR) < SPAN;
    assign ar_access_en = ar_in_range;
    // The address may have been latched in an earlier WR_COLLECT cycle
    assign wr_access_en = aw_hs ? aw_in_range : range_ok_q;
`else
    assign ar_access_en = 1'b1;
    assign wr_access_en = 1'b1;
`endif

    assign ar_hs   = axi.arvalid && axi.arready;
    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;

    // Arbitration and channel readies, decoded from the current state only
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        rd_sel      = 1'b0;
        wr_sel      = 1'b0;
        axi.arready = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        if (i_rst_n) begin
            if (state == IDLE) begin
                rd_sel      = axi.arvalid && (prefer_read || !(axi.awvalid || axi.wvalid));
                wr_sel      = !rd_sel && (axi.awvalid || axi.wvalid);
                axi.arready = rd_sel;
                axi.awready = wr_sel && !aw_got;
                axi.wready  = wr_sel && !w_got;
            end else if (state == WR_COLLECT) begin
                axi.awready = !aw_got;
                axi.wready  = !w_got;
            end
        end
    end

    // Transaction FSM with registered SRAM strobes and response valids
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the captured address/data registers are cleared on reset as well, so a dropped transaction leaves no stale id or data on the outputs.
            state       <= IDLE;
            prefer_read <= 1'b1;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            idx_q       <= '0;
            id_q        <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= AXI_RESP_OKAY;
            rvalid_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
            range_ok_q  <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            // Write address and data are latched independently, in any order.
            // BASE_ADDR is window-aligned, so the low bits already give the word index.
            if (aw_hs) begin
                idx_q  <= axi.awaddr[IDX_W+1:2];
                id_q   <= axi.awid;
                aw_got <= 1'b1;
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
                range_ok_q <= aw_in_range;
`endif
            end
            if (w_hs) begin
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb;
                w_got   <= 1'b1;
            end

            case (state)
                IDLE, WR_COLLECT: begin
                    if (ar_hs) begin
                        idx_q     <= axi.araddr[IDX_W+1:2];
                        id_q      <= axi.arid;
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
                        range_ok_q <= ar_in_range;
`endif
                        mem_req_q <= ar_access_en;
                        mem_wen_q <= 1'b0;
                        state     <= RD_MEM;
                    end else if (wr_sel || state == WR_COLLECT) begin
                        if (aw_have && w_have) begin
                            mem_req_q <= wr_access_en;
                            mem_wen_q <= 1'b1;
                            state     <= WR_MEM;
                        end else begin
                            state <= WR_COLLECT;
                        end
                    end
                end

                WR_MEM: begin
                    mem_req_q <= 1'b0;
                    mem_wen_q <= 1'b0;
                    aw_got    <= 1'b0;
                    w_got     <= 1'b0;
                    bvalid_q  <= 1'b1;
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
                    resp_q    <= range_ok_q ? AXI_RESP_OKAY : AXI_RESP_DECERR;
`else
                    resp_q    <= AXI_RESP_OKAY;
`endif
                    state     <= WR_RESP;
                end

                WR_RESP: begin
                    if (axi.bready) begin
                        bvalid_q    <= 1'b0;
                        prefer_read <= 1'b1;
                        state       <= IDLE;
                    end
                end

                RD_MEM: begin
                    mem_req_q <= 1'b0;
                    state     <= RD_CAPTURE;
                end

                RD_CAPTURE: begin
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
                    rdata_q  <= range_ok_q ? i_mem_rdata : '0;
                    resp_q   <= range_ok_q ? AXI_RESP_OKAY : AXI_RESP_DECERR;
`else
                    rdata_q  <= i_mem_rdata;
                    resp_q   <= AXI_RESP_OKAY;
`endif
                    rvalid_q <= 1'b1;
                    state    <= RD_RESP;
                end

                RD_RESP: begin
                    if (axi.rready) begin
                        rvalid_q    <= 1'b0;
                        prefer_read <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = resp_q;
    assign axi.rid     = id_q;
    assign axi.rlast   = 1'b1;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = resp_q;
    assign axi.bid     = id_q;

    assign o_mem_req   = mem_req_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_idx   = idx_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;

    // Bursts are not supported; they are served as a single beat and flagged here
    ar_single_beat: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ar_hs |-> (axi.arlen == 8'd0 && axi.arburst == AXI_BURST_FIXED));
    aw_single_beat: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        aw_hs |-> (axi.awlen == 8'd0 && axi.awburst == AXI_BURST_FIXED));
    w_single_beat: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_hs |-> axi.wlast);

endmodule : letc_axi_sram_subordinate

// File: tb/tb_letc_axi_sram_subordinate.sv
// Self-checking bench for letc_axi_sram_subordinate: a vector table of single
// reads/writes with latency checks, then hand-written sequences for W-before-AW,
// arbitration, backpressure, address window handling and mid-response reset.
// Expectations for the window case follow LETC_AXI_SUB_RANGE_CHECK_EN.
module tb_letc_axi_sram_subordinate;
    import letc_axi_sram_subordinate_pkg::*;

    localparam int     DEPTH = 1024;
    localparam paddr_t BASE  = 34'h0_8000_0000;
    localparam int     IDW   = 4;
    localparam int     IDX_W = $clog2(DEPTH);

    typedef struct {
        bit             wr;
        paddr_t         addr;
        logic [IDW-1:0] id;
        word_t          wdata;
        logic [3:0]     strb;
        word_t          exp_rdata;
        int             exp_idx;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_req;
    logic             mem_wen;
    logic [IDX_W-1:0] mem_idx;
    word_t            mem_wdata;
    logic [3:0]       mem_wstrb;
    word_t            mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    letc_axi_sram_subordinate_if #(.IDWIDTH(IDW)) axi ();

    letc_axi_sram_subordinate #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .IDWIDTH     (IDW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .axi         (axi),
        .o_mem_req   (mem_req),
        .o_mem_wen   (mem_wen),
        .o_mem_idx   (mem_idx),
        .o_mem_wdata (mem_wdata),
        .o_mem_wstrb (mem_wstrb),
        .i_mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model with one cycle of read latency, plus a log of the last access
    word_t            mem [DEPTH];
    bit               loaded = 1'b0;
    int               req_cnt = 0;
    logic             last_wen = 1'b0;
    logic [IDX_W-1:0] last_idx = '0;
    logic [3:0]       last_strb = '0;
    word_t            last_wdata = '0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h600D_F00D;
            mem[5] <= 32'hDEAD_BEEF;
            loaded <= 1'b1;
        end else if (mem_req) begin
            req_cnt    <= req_cnt + 1;
            last_wen   <= mem_wen;
            last_idx   <= mem_idx;
            last_strb  <= mem_wstrb;
            last_wdata <= mem_wdata;
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_idx];
            end
        end
    end

    // Order of completed responses while the arbitration sequence runs: 1 = R, 2 = B
    logic       arb_on = 1'b0;
    int         n_resp = 0;
    logic [1:0] order_log [8];

    always @(posedge clk) begin
        if (arb_on && n_resp < 8) begin
            if (axi.rvalid && axi.rready) begin
                order_log[n_resp] <= 2'd1;
                n_resp <= n_resp + 1;
            end else if (axi.bvalid && axi.bready) begin
                order_log[n_resp] <= 2'd2;
                n_resp <= n_resp + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Single read with no backpressure; lat counts cycles from AR handshake to rvalid
    task automatic do_read(input paddr_t addr, input logic [IDW-1:0] id,
                           output word_t rdata, output logic [1:0] resp,
                           output logic [IDW-1:0] rid, output logic rlast, output int lat);
        @(negedge clk);
        axi.araddr  = addr;
        axi.arid    = id;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        #1;
        for (int t = 0; t < 20 && !axi.arready; t++) begin
            @(negedge clk);
            #1;
        end
        check("ar_accept", axi.arready, 1'b1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        lat = 1;
        while (!axi.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = axi.rdata;
        resp  = axi.rresp;
        rid   = axi.rid;
        rlast = axi.rlast;
    endtask

    // Single write with AW and W together; lat counts cycles from handshake to bvalid
    task automatic do_write(input paddr_t addr, input logic [IDW-1:0] id,
                            input word_t data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [IDW-1:0] bid,
                            output int lat);
        @(negedge clk);
        axi.awaddr  = addr;
        axi.awid    = id;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b1;
        #1;
        for (int t = 0; t < 20 && !(axi.awready && axi.wready); t++) begin
            @(negedge clk);
            #1;
        end
        check("aw_w_accept", axi.awready && axi.wready, 1'b1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        lat = 1;
        while (!axi.bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        resp = axi.bresp;
        bid  = axi.bid;
    endtask

    initial begin
        vec_t           vecs [9];
        word_t          rdata;
        logic [1:0]     resp;
        logic [IDW-1:0] rid;
        logic           rlast;
        int             lat;
        int             req0;

        axi.arvalid = 1'b0;  axi.araddr = '0;  axi.arid = '0;
        axi.arlen   = 8'd0;  axi.arburst = AXI_BURST_FIXED;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;  axi.awaddr = '0;  axi.awid = '0;
        axi.awlen   = 8'd0;  axi.awburst = AXI_BURST_FIXED;
        axi.wvalid  = 1'b0;  axi.wdata = '0;   axi.wstrb = '0;  axi.wlast = 1'b1;
        axi.bready  = 1'b0;

        vecs[0] = '{wr: 1'b0, addr: BASE + 34'h014, id: 4'd3,  wdata: 32'h0,         strb: 4'h0, exp_rdata: 32'hDEAD_BEEF, exp_idx: 5};
        vecs[1] = '{wr: 1'b1, addr: BASE + 34'h020, id: 4'd5,  wdata: 32'hA5A5_5A5A, strb: 4'hF, exp_rdata: 32'h0,         exp_idx: 8};
        vecs[2] = '{wr: 1'b0, addr: BASE + 34'h020, id: 4'd6,  wdata: 32'h0,         strb: 4'h0, exp_rdata: 32'hA5A5_5A5A, exp_idx: 8};
        vecs[3] = '{wr: 1'b1, addr: BASE + 34'h022, id: 4'd7,  wdata: 32'h1122_3344, strb: 4'h1, exp_rdata: 32'h0,         exp_idx: 8};
        vecs[4] = '{wr: 1'b0, addr: BASE + 34'h023, id: 4'd1,  wdata: 32'h0,         strb: 4'h0, exp_rdata: 32'hA5A5_5A44, exp_idx: 8};
        vecs[5] = '{wr: 1'b1, addr: BASE + 34'hFFC, id: 4'd2,  wdata: 32'hCAFE_F00D, strb: 4'hF, exp_rdata: 32'h0,         exp_idx: 1023};
        vecs[6] = '{wr: 1'b0, addr: BASE + 34'hFFC, id: 4'd9,  wdata: 32'h0,         strb: 4'h0, exp_rdata: 32'hCAFE_F00D, exp_idx: 1023};
        vecs[7] = '{wr: 1'b1, addr: BASE + 34'h014, id: 4'd4,  wdata: 32'hFFFF_FFFF, strb: 4'h0, exp_rdata: 32'h0,         exp_idx: 5};
        vecs[8] = '{wr: 1'b0, addr: BASE + 34'h014, id: 4'd15, wdata: 32'h0,         strb: 4'h0, exp_rdata: 32'hDEAD_BEEF, exp_idx: 5};

        // Reset state, including readies held low while reset is asserted
        repeat (3) @(negedge clk);
        check("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_bvalid", axi.bvalid, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        axi.arvalid = 1'b1;
        #1;
        check("rst_arready", axi.arready, 1'b0);
        axi.arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: single transactions with zero backpressure
        for (int i = 0; i < 9; i++) begin
            req0 = req_cnt;
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].id, vecs[i].wdata, vecs[i].strb, resp, rid, lat);
                check($sformatf("v%0d_b_latency", i), lat, 2);
                check($sformatf("v%0d_bresp", i), resp, AXI_RESP_OKAY);
                check($sformatf("v%0d_bid", i), rid, vecs[i].id);
                check($sformatf("v%0d_mem_wen", i), last_wen, 1'b1);
                check($sformatf("v%0d_mem_strb", i), last_strb, vecs[i].strb);
                check($sformatf("v%0d_mem_wdata", i), last_wdata, vecs[i].wdata);
            end else begin
                do_read(vecs[i].addr, vecs[i].id, rdata, resp, rid, rlast, lat);
                check($sformatf("v%0d_r_latency", i), lat, 3);
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
                check($sformatf("v%0d_rresp", i), resp, AXI_RESP_OKAY);
                check($sformatf("v%0d_rid", i), rid, vecs[i].id);
                check($sformatf("v%0d_rlast", i), rlast, 1'b1);
                check($sformatf("v%0d_mem_wen", i), last_wen, 1'b0);
            end
            check($sformatf("v%0d_mem_idx", i), last_idx, vecs[i].exp_idx);
            check($sformatf("v%0d_req_count", i), req_cnt - req0, 1);
        end

        // W arrives two cycles before AW
        req0 = req_cnt;
        @(negedge clk);
        axi.wdata  = 32'h1122_3344;
        axi.wstrb  = 4'b0100;
        axi.wvalid = 1'b1;
        axi.bready = 1'b1;
        #1;
        check("wfirst_wready_c0", axi.wready, 1'b1);
        @(negedge clk);
        axi.wvalid = 1'b0;
        #1;
        check("wfirst_wready_c1", axi.wready, 1'b0);
        @(negedge clk);
        axi.awaddr  = BASE + 34'h008;
        axi.awid    = 4'd2;
        axi.awvalid = 1'b1;
        #1;
        check("wfirst_awready_c2", axi.awready, 1'b1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int t = 0; t < 20 && !axi.bvalid; t++) @(negedge clk);
        check("wfirst_bvalid", axi.bvalid, 1'b1);
        check("wfirst_bresp", axi.bresp, AXI_RESP_OKAY);
        check("wfirst_bid", axi.bid, 4'd2);
        check("wfirst_req_count", req_cnt - req0, 1);
        check("wfirst_mem_wen", last_wen, 1'b1);
        check("wfirst_mem_idx", last_idx, 2);
        check("wfirst_mem_strb", last_strb, 4'b0100);
        check("wfirst_mem_wdata", last_wdata, 32'h1122_3344);

        // Continuous simultaneous read and write requests alternate R, W, R, W
        @(negedge clk);
        axi.araddr  = BASE + 34'h014;
        axi.arid    = 4'd1;
        axi.awaddr  = BASE + 34'h040;
        axi.awid    = 4'd2;
        axi.wdata   = 32'h0BAD_CAFE;
        axi.wstrb   = 4'hF;
        axi.arvalid = 1'b1;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.rready  = 1'b1;
        axi.bready  = 1'b1;
        arb_on      = 1'b1;
        for (int t = 0; t < 60 && n_resp < 4; t++) @(negedge clk);
        axi.arvalid = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        arb_on      = 1'b0;
        check("arb_resp_count", n_resp, 4);
        check("arb_order_0", order_log[0], 2'd1);
        check("arb_order_1", order_log[1], 2'd2);
        check("arb_order_2", order_log[2], 2'd1);
        check("arb_order_3", order_log[3], 2'd2);

        // Read response held under five cycles of rready low
        @(negedge clk);
        axi.araddr  = BASE + 34'h014;
        axi.arid    = 4'd3;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        #1;
        check("bp_arready", axi.arready, 1'b1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        for (int t = 0; t < 20 && !axi.rvalid; t++) @(negedge clk);
        axi.araddr  = BASE + 34'h020;
        axi.arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_rvalid_c%0d", c), axi.rvalid, 1'b1);
            check($sformatf("bp_rdata_c%0d", c), axi.rdata, 32'hDEAD_BEEF);
            check($sformatf("bp_no_arready_c%0d", c), axi.arready, 1'b0);
            @(negedge clk);
        end
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        @(negedge clk);
        check("bp_rvalid_after_hs", axi.rvalid, 1'b0);

        // Address one past the window and one word below it
        req0 = req_cnt;
        do_read(BASE + 34'h1000, 4'd10, rdata, resp, rid, rlast, lat);
        check("range_rd_latency", lat, 3);
        check("range_rd_rid", rid, 4'd10);
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
        check("range_rd_req_count", req_cnt - req0, 0);
        check("range_rd_rresp", resp, AXI_RESP_DECERR);
        check("range_rd_rdata", rdata, 32'h0);
`else
        check("range_rd_req_count", req_cnt - req0, 1);
        check("range_rd_rresp", resp, AXI_RESP_OKAY);
        check("range_rd_rdata", rdata, 32'h600D_F00D);
`endif
        req0 = req_cnt;
        do_write(BASE - 34'h4, 4'd11, 32'h1234_5678, 4'h0, resp, rid, lat);
        check("range_wr_latency", lat, 2);
        check("range_wr_bid", rid, 4'd11);
`ifdef LETC_AXI_SUB_RANGE_CHECK_EN
        check("range_wr_req_count", req_cnt - req0, 0);
        check("range_wr_bresp", resp, AXI_RESP_DECERR);
`else
        check("range_wr_req_count", req_cnt - req0, 1);
        check("range_wr_bresp", resp, AXI_RESP_OKAY);
        check("range_wr_mem_idx", last_idx, 1023);
`endif

        // Reset asserted while a read response is waiting for rready
        @(negedge clk);
        axi.araddr  = BASE + 34'h014;
        axi.arid    = 4'd3;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        #1;
        check("rstmid_arready", axi.arready, 1'b1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        for (int t = 0; t < 20 && !axi.rvalid; t++) @(negedge clk);
        check("rstmid_rvalid_before", axi.rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        axi.arvalid = 1'b1;
        #1;
        check("rstmid_rvalid_async", axi.rvalid, 1'b0);
        check("rstmid_arready_in_rst", axi.arready, 1'b0);
        check("rstmid_mem_req", mem_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_arready_idle", axi.arready, 1'b1);
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid_no_r_c%0d", c), axi.rvalid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_letc_axi_sram_subordinate
